usb_feature_unit_ctrl: RTL and testbench

Parametrised USB Audio Class 1.0 Feature Unit control handler for the endpoint-0 control path. Serves class-specific interface requests (SET_CUR, GET_CUR/MIN/MAX/RES) for Mute and Volume on a master channel plus CHANNELS logical channels. Volume is 16-bit signed, in 1/256 dB, with per-channel mute. Sits beside the standard-request decoder, which parses SETUP and strobes this block on class requests; it drives the IN/OUT byte handshakes for the data and status stages.

---
 rtl/usb_feature_unit_ctrl_pkg.sv | 42 ++++
 rtl/fu_volume_ramp.sv | 53 +++++
 rtl/usb_feature_unit_ctrl.sv | 289 ++++++++++++++++++++++++++++
 tb/tb_usb_feature_unit_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_feature_unit_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : usb_feature_unit_ctrl_pkg
// Description : Shared definitions for the UAC1 Feature Unit control handler:
//               class request codes, control selectors, FSM states and the
//               natural payload size of each control.
// Revision    : 1.0 - initial release
// ============================================================================
package usb_feature_unit_ctrl_pkg;

    // Class-specific request codes (bRequest)
    localparam logic [7:0] c_SET_CUR = 8'h01;
    localparam logic [7:0] c_GET_CUR = 8'h81;
    localparam logic [7:0] c_GET_MIN = 8'h82;
    localparam logic [7:0] c_GET_MAX = 8'h83;
    localparam logic [7:0] c_GET_RES = 8'h84;

    // Feature Unit control selectors (wValue[15:8])
    localparam logic [7:0] c_MUTE_CONTROL   = 8'h01;
    localparam logic [7:0] c_VOLUME_CONTROL = 8'h02;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_DECODE     = 3'd1,
        ST_RECV_DATA  = 3'd2,
        ST_STATUS_IN  = 3'd3,
        ST_SEND_DATA  = 3'd4,
        ST_WAIT_ACK   = 3'd5,
        ST_STATUS_OUT = 3'd6
    } fu_state_t;

    // Payload size in bytes of a control; 0 marks an unsupported selector
    function automatic logic [1:0] natural_size(input logic [7:0] cs);
        case (cs)
            c_MUTE_CONTROL:   natural_size = 2'd1;
            c_VOLUME_CONTROL: natural_size = 2'd2;
            default:          natural_size = 2'd0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/fu_volume_ramp.sv
`default_nettype none
// ============================================================================
// Module      : fu_volume_ramp
// Description : Per-channel volume smoother. Steps the output by VOL_RES
//               toward the target once every 2^RAMP_SHIFT clocks; a residual
//               smaller than VOL_RES lands directly on the target.
// Revision    : 1.0 - initial release
// ============================================================================
module fu_volume_ramp #(
    parameter logic [15:0] VOL_RES     = 16'h0100,
    parameter logic [15:0] VOL_DEFAULT = 16'hF400,
    parameter int          RAMP_SHIFT  = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] i_target,
    output logic [15:0] o_volume
);

    logic [RAMP_SHIFT-1:0] r_tick;
    logic [15:0]           r_vol;
    logic [16:0]           w_diff;
    logic [16:0]           w_mag;

    // Signed distance to target, sign-extended so it never overflows
    always_comb begin
        w_diff = {i_target[15], i_target} - {r_vol[15], r_vol};
        w_mag  = w_diff[16] ? (17'd0 - w_diff) : w_diff;
    end

    // Free-running tick counter; one step toward the target per wrap
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tick <= '0;
            r_vol  <= VOL_DEFAULT;
        end else begin
            r_tick <= r_tick + 1'b1;
            if (&r_tick) begin
                if (w_mag < {1'b0, VOL_RES}) begin
                    r_vol <= i_target;
                end else if (w_diff[16]) begin
                    r_vol <= r_vol - VOL_RES;
                end else begin
                    r_vol <= r_vol + VOL_RES;
                end
            end
        end
    end

    assign o_volume = r_vol;

endmodule
`default_nettype wire

// File: rtl/usb_feature_unit_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : usb_feature_unit_ctrl
// Description : USB Audio Class 1.0 Feature Unit control handler (Mute and
//               Volume, master + CHANNELS logical channels) on endpoint 0.
//               Optional: FU_VOLUME_RAMP_EN smooths Volume outputs toward the
//               committed targets through one fu_volume_ramp per channel.
// Revision    : 1.0 - initial release
// ============================================================================
module usb_feature_unit_ctrl
    import usb_feature_unit_ctrl_pkg::*;
#(
    parameter int          CHANNELS    = 2,
    parameter logic [7:0]  UNIT_ID     = 8'd2,
    parameter logic [7:0]  INTERFACE   = 8'd0,
    parameter logic [15:0] VOL_MIN     = 16'hC400,
    parameter logic [15:0] VOL_MAX     = 16'h0000,
    parameter logic [15:0] VOL_RES     = 16'h0100,
    parameter logic [15:0] VOL_DEFAULT = 16'hF400,
    parameter int          RAMP_SHIFT  = 10
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic                      Setup_Valid,
    input  logic [7:0]                Setup_Request,
    input  logic [15:0]               Setup_Value,
    input  logic [15:0]               Setup_Index,
    input  logic [15:0]               Setup_Length,
    input  logic                      Error,
    input  logic [7:0]                OUT_Data,
    input  logic                      OUT_Valid,
    input  logic                      OUT_EoP,
    output logic [7:0]                IN_Data,
    output logic                      IN_Ready,
    output logic                      IN_ZeroLength,
    input  logic                      IN_WaitRequest,
    input  logic                      IN_Ack,
    output logic                      IN_Sequence,
    output logic                      Stall,
    output logic                      Changed,
    output logic [CHANNELS:0]         Mute,
    output logic [16*(CHANNELS+1)-1:0] Volume
);

    localparam logic [7:0] c_MAX_CN = 8'(CHANNELS);

    fu_state_t   r_state;
    logic [7:0]  r_req;
    logic [7:0]  r_cs;
    logic [7:0]  r_cn;
    logic [15:0] r_index;
    logic [15:0] r_len;
    logic [1:0]  r_cnt;
    logic [1:0]  r_size;
    logic [15:0] r_resp;
    logic [7:0]  r_rx_byte0;
    logic [7:0]  r_in_data;
    logic        r_in_ready;
    logic        r_in_zlp;
    logic        r_in_seq;
    logic        r_stall;
    logic        r_changed;
    logic [CHANNELS:0] r_mute;
    logic [15:0] r_vol_tgt [CHANNELS+1];

    logic        w_is_mute;
    logic        w_is_vol;
    logic        w_is_set;
    logic        w_is_get;
    logic [1:0]  w_nat;
    logic        w_bad;
    logic        w_cur_mute;
    logic [15:0] w_cur_vol;
    logic [15:0] w_resp;
    logic [1:0]  w_size;
    logic [15:0] w_rx_vol;
    logic [15:0] w_clamped;

    // Request validation and GET response selection from the latched SETUP
    always_comb begin
        w_is_mute  = (r_cs == c_MUTE_CONTROL);
        w_is_vol   = (r_cs == c_VOLUME_CONTROL);
        w_is_set   = (r_req == c_SET_CUR);
        w_is_get   = (r_req == c_GET_CUR) || (r_req == c_GET_MIN) ||
                     (r_req == c_GET_MAX) || (r_req == c_GET_RES);
        w_nat      = natural_size(r_cs);
        w_cur_mute = 1'b0;
        w_cur_vol  = '0;
        for (int n = 0; n <= CHANNELS; n++) begin
            if (r_cn == 8'(n)) begin
                w_cur_mute = r_mute[n];
                w_cur_vol  = r_vol_tgt[n];
            end
        end
        w_bad = (r_index != {UNIT_ID, INTERFACE}) ||
                !(w_is_mute || w_is_vol) ||
                (r_cn > c_MAX_CN) ||
                !(w_is_set || w_is_get) ||
                (w_is_mute && w_is_get && (r_req != c_GET_CUR)) ||
                (w_is_set && (r_len != {14'd0, w_nat}));
        case (r_req)
            c_GET_MIN: w_resp = VOL_MIN;
            c_GET_MAX: w_resp = VOL_MAX;
            c_GET_RES: w_resp = VOL_RES;
            default:   w_resp = w_is_mute ? {15'd0, w_cur_mute} : w_cur_vol;
        endcase
        w_size = (r_len < {14'd0, w_nat}) ? r_len[1:0] : w_nat;
    end

    // Incoming volume assembled little-endian and clamped to the legal range
    always_comb begin
        w_rx_vol = {OUT_Data, r_rx_byte0};
        if ($signed(w_rx_vol) < $signed(VOL_MIN)) begin
            w_clamped = VOL_MIN;
        end else if ($signed(w_rx_vol) > $signed(VOL_MAX)) begin
            w_clamped = VOL_MAX;
        end else begin
            w_clamped = w_rx_vol;
        end
    end

    // Control-transfer FSM; a new SETUP overrides whatever is in flight
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state    <= ST_IDLE;
            r_req      <= '0;
            r_cs       <= '0;
            r_cn       <= '0;
            r_index    <= '0;
            r_len      <= '0;
            r_cnt      <= '0;
            r_size     <= '0;
            r_resp     <= '0;
            r_rx_byte0 <= '0;
            r_in_data  <= '0;
            r_in_ready <= 1'b0;
            r_in_zlp   <= 1'b0;
            r_in_seq   <= 1'b0;
            r_stall    <= 1'b0;
            r_changed  <= 1'b0;
            r_mute     <= '0;
            for (int n = 0; n <= CHANNELS; n++) begin
                r_vol_tgt[n] <= VOL_DEFAULT;
            end
        end else begin
            r_changed <= 1'b0;
            if (Setup_Valid) begin
                r_stall    <= 1'b0;
                r_in_ready <= 1'b0;
                r_in_seq   <= 1'b1;
                r_req      <= Setup_Request;
                r_cs       <= Setup_Value[15:8];
                r_cn       <= Setup_Value[7:0];
                r_index    <= Setup_Index;
                r_len      <= Setup_Length;
                r_cnt      <= '0;
                r_state    <= ST_DECODE;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        r_state <= ST_IDLE;
                    end
                    ST_DECODE: begin
                        r_cnt <= '0;
                        if (w_bad) begin
                            r_stall <= 1'b1;
                            r_state <= ST_IDLE;
                        end else if (w_is_set) begin
                            r_state <= ST_RECV_DATA;
                        end else begin
                            r_resp    <= w_resp;
                            r_size    <= w_size;
                            r_in_data <= w_resp[7:0];
                            r_in_zlp  <= (w_size == 2'd0);
                            r_state   <= ST_SEND_DATA;
                        end
                    end
                    ST_RECV_DATA: begin
                        if (OUT_Valid && OUT_EoP) begin
                            if (({1'b0, r_cnt} + 3'd1) == {1'b0, w_nat}) begin
                                for (int n = 0; n <= CHANNELS; n++) begin
                                    if (r_cn == 8'(n)) begin
                                        if (w_is_mute) begin
                                            r_mute[n] <= OUT_Data[0];
                                        end else begin
                                            r_vol_tgt[n] <= w_clamped;
                                        end
                                    end
                                end
                                r_changed  <= 1'b1;
                                r_in_zlp   <= 1'b1;
                                r_in_ready <= 1'b1;
                                r_state    <= ST_STATUS_IN;
                            end else begin
                                r_stall <= 1'b1;
                                r_state <= ST_IDLE;
                            end
                        end else if (OUT_Valid) begin
                            if (r_cnt == 2'd0) begin
                                r_rx_byte0 <= OUT_Data;
                            end
                            if (r_cnt != 2'd3) begin
                                r_cnt <= r_cnt + 2'd1;
                            end
                        end
                    end
                    ST_STATUS_IN: begin
                        if (IN_Ack) begin
                            r_in_ready <= 1'b0;
                            r_state    <= ST_IDLE;
                        end
                    end
                    ST_SEND_DATA: begin
                        if (OUT_Valid && OUT_EoP) begin
                            // Host moved to the status stage early
                            r_in_ready <= 1'b0;
                            r_state    <= ST_IDLE;
                        end else if (!r_in_ready) begin
                            r_in_ready <= 1'b1;
                        end else if (!IN_WaitRequest) begin
                            if ((r_size == 2'd0) || (r_cnt == (r_size - 2'd1))) begin
                                r_in_ready <= 1'b0;
                                r_state    <= ST_WAIT_ACK;
                            end else begin
                                r_cnt     <= r_cnt + 2'd1;
                                r_in_data <= r_resp[15:8];
                            end
                        end
                    end
                    ST_WAIT_ACK: begin
                        if (Error) begin
                            r_cnt     <= '0;
                            r_in_data <= r_resp[7:0];
                            r_state   <= ST_SEND_DATA;
                        end else if (IN_Ack) begin
                            r_in_seq <= ~r_in_seq;
                            r_state  <= ST_STATUS_OUT;
                        end
                    end
                    ST_STATUS_OUT: begin
                        if (OUT_Valid && OUT_EoP) begin
                            r_state <= ST_IDLE;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign IN_Data       = r_in_data;
    assign IN_Ready      = r_in_ready;
    assign IN_ZeroLength = r_in_zlp;
    assign IN_Sequence   = r_in_seq;
    assign Stall         = r_stall;
    assign Changed       = r_changed;
    assign Mute          = r_mute;

`ifdef FU_VOLUME_RAMP_EN
    generate
        for (genvar g = 0; g <= CHANNELS; g++) begin : g_ramp
            fu_volume_ramp #(
                .VOL_RES     (VOL_RES),
                .VOL_DEFAULT (VOL_DEFAULT),
                .RAMP_SHIFT  (RAMP_SHIFT)
            ) u_ramp (
                .clk      (Clk),
                .rst      (Reset),
                .i_target (r_vol_tgt[g]),
                .o_volume (Volume[16*g +: 16])
            );
        end
    endgenerate
`else
    generate
        for (genvar g = 0; g <= CHANNELS; g++) begin : g_vol
            assign Volume[16*g +: 16] = r_vol_tgt[g];
        end
    endgenerate

    // Ramp timing has no effect when volume follows the target directly
    logic [31:0] w_ramp_shift_unused;
    assign w_ramp_shift_unused = RAMP_SHIFT;
`endif

endmodule
`default_nettype wire

// File: tb/tb_usb_feature_unit_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_usb_feature_unit_ctrl
// Description : Directed self-checking bench for usb_feature_unit_ctrl with a
//               queue of expected IN bytes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_usb_feature_unit_ctrl;

    localparam int CH = 2;

    logic        Clk;
    logic        Reset;
    logic        Setup_Valid;
    logic [7:0]  Setup_Request;
    logic [15:0] Setup_Value;
    logic [15:0] Setup_Index;
    logic [15:0] Setup_Length;
    logic        Error;
    logic [7:0]  OUT_Data;
    logic        OUT_Valid;
    logic        OUT_EoP;
    logic [7:0]  IN_Data;
    logic        IN_Ready;
    logic        IN_ZeroLength;
    logic        IN_WaitRequest;
    logic        IN_Ack;
    logic        IN_Sequence;
    logic        Stall;
    logic        Changed;
    logic [CH:0] Mute;
    logic [16*(CH+1)-1:0] Volume;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q [$];

    usb_feature_unit_ctrl #(.CHANNELS(CH)) dut (
        .Clk            (Clk),
        .Reset          (Reset),
        .Setup_Valid    (Setup_Valid),
        .Setup_Request  (Setup_Request),
        .Setup_Value    (Setup_Value),
        .Setup_Index    (Setup_Index),
        .Setup_Length   (Setup_Length),
        .Error          (Error),
        .OUT_Data       (OUT_Data),
        .OUT_Valid      (OUT_Valid),
        .OUT_EoP        (OUT_EoP),
        .IN_Data        (IN_Data),
        .IN_Ready       (IN_Ready),
        .IN_ZeroLength  (IN_ZeroLength),
        .IN_WaitRequest (IN_WaitRequest),
        .IN_Ack         (IN_Ack),
        .IN_Sequence    (IN_Sequence),
        .Stall          (Stall),
        .Changed        (Changed),
        .Mute           (Mute),
        .Volume         (Volume)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] vol(input int n);
        return Volume[16*n +: 16];
    endfunction

    // SETUP strobe only; the decode cycle is left to the caller
    task automatic setup(input logic [7:0] req, input logic [7:0] cs, input logic [7:0] cn,
                         input logic [7:0] unit, input logic [15:0] len);
        Setup_Valid   = 1'b1;
        Setup_Request = req;
        Setup_Value   = {cs, cn};
        Setup_Index   = {unit, 8'h00};
        Setup_Length  = len;
        tick();
        Setup_Valid   = 1'b0;
    endtask

    task automatic out_byte(input logic [7:0] d, input logic eop);
        OUT_Valid = 1'b1;
        OUT_Data  = d;
        OUT_EoP   = eop;
        tick();
        OUT_Valid = 1'b0;
        OUT_EoP   = 1'b0;
    endtask

    task automatic in_ack();
        IN_Ack = 1'b1;
        tick();
        IN_Ack = 1'b0;
    endtask

    // Pops and compares one expected byte per IN handshake, bounded in time
    task automatic drain_in(input string tag, input int n);
        int got = 0;
        for (int cyc = 0; cyc < 40 && got < n; cyc++) begin
            if (IN_Ready && !IN_WaitRequest) begin
                check(tag, {24'd0, IN_Data}, {24'd0, exp_q.pop_front()});
                got++;
            end
            tick();
        end
        check({tag, "_count"}, got, n);
    endtask

    initial begin
        Reset = 1'b1; Setup_Valid = 1'b0; Setup_Request = '0; Setup_Value = '0;
        Setup_Index = '0; Setup_Length = '0; Error = 1'b0; OUT_Data = '0;
        OUT_Valid = 1'b0; OUT_EoP = 1'b0; IN_WaitRequest = 1'b0; IN_Ack = 1'b0;
        repeat (3) tick();
        Reset = 1'b0;
        tick();

        // Reset state
        check("rst_mute", {29'd0, Mute}, 32'd0);
        for (int n = 0; n <= CH; n++) check("rst_vol", {16'd0, vol(n)}, 32'h0000F400);
        check("rst_ready", {31'd0, IN_Ready}, 32'd0);
        check("rst_stall", {31'd0, Stall}, 32'd0);
        check("rst_seq", {31'd0, IN_Sequence}, 32'd0);
        check("rst_data", {24'd0, IN_Data}, 32'd0);

        // SET_CUR volume CN1 = -20 dB
        setup(8'h01, 8'h02, 8'h01, 8'h02, 16'd2); tick();
        out_byte(8'h00, 1'b0);
        out_byte(8'hEC, 1'b1);
        check("set1_changed", {31'd0, Changed}, 32'd1);
        check("set1_vol1", {16'd0, vol(1)}, 32'h0000EC00);
        check("set1_vol2", {16'd0, vol(2)}, 32'h0000F400);
        check("set1_zlp", {31'd0, IN_ZeroLength}, 32'd1);
        check("set1_ready", {31'd0, IN_Ready}, 32'd1);
        in_ack();
        check("set1_ready_off", {31'd0, IN_Ready}, 32'd0);
        check("set1_chg_pulse", {31'd0, Changed}, 32'd0);
        check("set1_seq", {31'd0, IN_Sequence}, 32'd1);

        // Clamp high (+16 dB -> 0 dB) and clamp low (0x8000 -> -60 dB)
        setup(8'h01, 8'h02, 8'h02, 8'h02, 16'd2); tick();
        out_byte(8'h00, 1'b0); out_byte(8'h10, 1'b1); in_ack();
        check("clamp_hi", {16'd0, vol(2)}, 32'h00000000);
        setup(8'h01, 8'h02, 8'h00, 8'h02, 16'd2); tick();
        out_byte(8'h00, 1'b0); out_byte(8'h80, 1'b1); in_ack();
        check("clamp_lo", {16'd0, vol(0)}, 32'h0000C400);

        // SET_CUR mute CN0
        setup(8'h01, 8'h01, 8'h00, 8'h02, 16'd1); tick();
        out_byte(8'h01, 1'b1);
        check("mute_changed", {31'd0, Changed}, 32'd1);
        in_ack();
        check("mute_val", {29'd0, Mute}, 32'd1);

        // GET_MIN volume with an error-triggered resend
        setup(8'h82, 8'h02, 8'h01, 8'h02, 16'd2); tick();
        check("getmin_latency", {31'd0, IN_Ready}, 32'd0);
        exp_q.push_back(8'h00); exp_q.push_back(8'hC4);
        drain_in("getmin", 2);
        Error = 1'b1; tick(); Error = 1'b0;
        exp_q.push_back(8'h00); exp_q.push_back(8'hC4);
        drain_in("getmin_resend", 2);
        check("getmin_seq_hold", {31'd0, IN_Sequence}, 32'd1);
        in_ack();
        check("getmin_seq_tog", {31'd0, IN_Sequence}, 32'd0);
        out_byte(8'h00, 1'b1);
        check("getmin_idle", {31'd0, IN_Ready}, 32'd0);

        // GET_CUR volume with oversized wLength, GET_CUR mute, GET_RES
        setup(8'h81, 8'h02, 8'h01, 8'h02, 16'd8); tick();
        exp_q.push_back(8'h00); exp_q.push_back(8'hEC);
        drain_in("getcur_vol", 2); in_ack(); out_byte(8'h00, 1'b1);
        setup(8'h81, 8'h01, 8'h00, 8'h02, 16'd1); tick();
        exp_q.push_back(8'h01);
        drain_in("getcur_mute", 1); in_ack(); out_byte(8'h00, 1'b1);
        setup(8'h84, 8'h02, 8'h02, 8'h02, 16'd2); tick();
        exp_q.push_back(8'h00); exp_q.push_back(8'h01);
        drain_in("getres", 2); in_ack(); out_byte(8'h00, 1'b1);
        setup(8'h81, 8'h02, 8'h01, 8'h02, 16'd1); tick();
        exp_q.push_back(8'h00);
        drain_in("getcur_short", 1); in_ack(); out_byte(8'h00, 1'b1);

        // Zero-length GET_MAX
        setup(8'h83, 8'h02, 8'h01, 8'h02, 16'd0); tick(); tick();
        check("zlp_ready", {31'd0, IN_Ready}, 32'd1);
        check("zlp_flag", {31'd0, IN_ZeroLength}, 32'd1);
        tick();
        check("zlp_done", {31'd0, IN_Ready}, 32'd0);
        in_ack(); out_byte(8'h00, 1'b1);

        // Early host status during the data stage
        setup(8'h84, 8'h02, 8'h01, 8'h02, 16'd2); tick(); tick();
        IN_WaitRequest = 1'b1;
        out_byte(8'h00, 1'b1);
        IN_WaitRequest = 1'b0;
        tick();
        check("early_eop", {31'd0, IN_Ready}, 32'd0);

        // Protocol stalls
        setup(8'h81, 8'h02, 8'h03, 8'h02, 16'd2); tick();
        check("stall_cn", {31'd0, Stall}, 32'd1);
        setup(8'h83, 8'h01, 8'h00, 8'h02, 16'd1);
        check("stall_clear", {31'd0, Stall}, 32'd0);
        tick();
        check("stall_mute_max", {31'd0, Stall}, 32'd1);
        setup(8'h81, 8'h02, 8'h01, 8'h05, 16'd2); tick();
        check("stall_unit", {31'd0, Stall}, 32'd1);
        setup(8'h01, 8'h01, 8'h00, 8'h02, 16'd2); tick();
        check("stall_set_len", {31'd0, Stall}, 32'd1);

        // Short SET_CUR payload: stall, no commit
        setup(8'h01, 8'h02, 8'h01, 8'h02, 16'd2); tick();
        out_byte(8'h00, 1'b1);
        check("short_stall", {31'd0, Stall}, 32'd1);
        check("short_nochg", {31'd0, Changed}, 32'd0);
        check("short_vol", {16'd0, vol(1)}, 32'h0000EC00);

        // New SETUP aborts a stalled data stage and is served
        IN_WaitRequest = 1'b1;
        setup(8'h81, 8'h02, 8'h01, 8'h02, 16'd2); tick(); tick();
        check("abort_ready", {31'd0, IN_Ready}, 32'd1);
        tick();
        check("abort_hold", {24'd0, IN_Data}, 32'd0);
        setup(8'h81, 8'h01, 8'h00, 8'h02, 16'd1);
        check("abort_drop", {31'd0, IN_Ready}, 32'd0);
        IN_WaitRequest = 1'b0;
        tick();
        exp_q.push_back(8'h01);
        drain_in("abort_new", 1);
        in_ack();
        check("abort_seq", {31'd0, IN_Sequence}, 32'd0);
        out_byte(8'h00, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
